// File: rtl/bf_stdin_uart_rx.sv
// UART receiver (8N1, LSB first) feeding a show-ahead byte FIFO that
// supplies the stdin stream consumed by the brainfuck core's ',' instruction.
module bf_stdin_uart_rx #(
   parameter int UART_RX_BAUD    = 4,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx_pin,
   output logic [7:0] stdin,
   output logic       stdin_valid,
   input  logic       stdin_rd,
   output logic       overflow,
   output logic       framing_error,
   input  logic       err_clear
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CNT_W = $clog2(UART_RX_BAUD);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(UART_RX_BAUD / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(UART_RX_BAUD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [FIFO_DEPTH_LOG2:0]   OCC_ONE = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [FIFO_DEPTH_LOG2:0]   OCC_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // ---------------------------------------------------------------------
   // Input synchroniser: presets to the idle-high line level so reset never
   // looks like a start bit.
   // ---------------------------------------------------------------------
   logic sync1_q;
   logic rx_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge value of its source, whatever the block order.
         sync1_q <= uart_rx_pin;
         rx_s_q  <= sync1_q;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;

   logic expiry;
   logic stop_ok;
   logic stop_bad;

   assign expiry   = (cnt_q == '0);
   assign stop_ok  = (state_q == S_STOP) && expiry && rx_s_q;
   assign stop_bad = (state_q == S_STOP) && expiry && !rx_s_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_q <= S_START;
                  cnt_q   <= HALF_LOAD;
               end
            end
            S_START: begin
               if (!expiry) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if (rx_s_q) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q   <= S_DATA;
                  bit_idx_q <= '0;
                  cnt_q     <= FULL_LOAD;
               end
            end
            S_DATA: begin
               if (!expiry) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  shift_q[bit_idx_q] <= rx_s_q;
                  cnt_q              <= FULL_LOAD;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
            S_STOP: begin
               if (!expiry) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if (rx_s_q) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_BREAK;
               end
            end
            S_BREAK: begin
               // Wait out a held-low line so it reports a single framing error.
               if (rx_s_q) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------------
   logic [7:0]                 mem_q [0:DEPTH-1];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
   logic                       overflow_q, overflow_d;
   logic                       framing_error_q, framing_error_d;

   logic pop;
   logic push_ok;
   logic drop;

   assign pop     = stdin_rd && (count_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok = stop_ok && ((count_q != OCC_FULL) || pop);
   assign drop    = stop_ok && !push_ok;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      overflow_d      = overflow_q | drop;
      framing_error_d = framing_error_q | stop_bad;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + OCC_ONE;
         2'b01:   count_d = count_q - OCC_ONE;
         default: count_d = count_q;
      endcase

      if (err_clear) begin
         overflow_d      = 1'b0;
         framing_error_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         overflow_q      <= 1'b0;
         framing_error_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         overflow_q      <= overflow_d;
         framing_error_q <= framing_error_d;
      end
   end

   // NOTE: storage is deliberately not reset; the occupancy count alone
   // decides what is valid, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign stdin_valid   = (count_q != '0);
   assign stdin         = stdin_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign overflow      = overflow_q;
   assign framing_error = framing_error_q;

endmodule

// File: tb/tb_bf_stdin_uart_rx.sv
// Directed bench for bf_stdin_uart_rx: table of single-byte round trips plus
// hand-written sequences for FIFO, overflow, glitch, framing and reset cases.
module tb_bf_stdin_uart_rx;

   localparam int BAUD = 4;
   localparam int LOG2 = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx_pin;
   logic [7:0] stdin;
   logic       stdin_valid;
   logic       stdin_rd;
   logic       overflow;
   logic       framing_error;
   logic       err_clear;

   int tests  = 0;
   int failed = 0;

   bf_stdin_uart_rx #(
      .UART_RX_BAUD   (BAUD),
      .FIFO_DEPTH_LOG2(LOG2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rx_pin  (uart_rx_pin),
      .stdin        (stdin),
      .stdin_valid  (stdin_valid),
      .stdin_rd     (stdin_rd),
      .overflow     (overflow),
      .framing_error(framing_error),
      .err_clear    (err_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      logic [7:0] exp_stdin;
      logic       exp_valid;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one 8N1 frame starting at a negedge; the stop level is left on the line.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      uart_rx_pin = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx_pin = data[i];
         repeat (BAUD) @(negedge clk);
      end
      uart_rx_pin = stop_bit;
      repeat (BAUD) @(negedge clk);
   endtask

   task automatic pop_check(input string name, input logic [7:0] exp);
      check(name, 32'(stdin), 32'(exp));
      stdin_rd = 1'b1;
      @(negedge clk);
      stdin_rd = 1'b0;
   endtask

   vec_t vecs [6];
   int   lat;

   initial begin
      vecs[0] = '{data: 8'hFF, exp_stdin: 8'hFF, exp_valid: 1'b1};
      vecs[1] = '{data: 8'h00, exp_stdin: 8'h00, exp_valid: 1'b1};
      vecs[2] = '{data: 8'h80, exp_stdin: 8'h80, exp_valid: 1'b1};
      vecs[3] = '{data: 8'h01, exp_stdin: 8'h01, exp_valid: 1'b1};
      vecs[4] = '{data: 8'hA5, exp_stdin: 8'hA5, exp_valid: 1'b1};
      vecs[5] = '{data: 8'h5A, exp_stdin: 8'h5A, exp_valid: 1'b1};

      rst         = 1'b1;
      uart_rx_pin = 1'b1;
      stdin_rd    = 1'b0;
      err_clear   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_stdin", 32'(stdin), 32'h0);
      check("reset_valid", 32'(stdin_valid), 32'h0);
      check("reset_overflow", 32'(overflow), 32'h0);
      check("reset_framing", 32'(framing_error), 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 'A' with latency measured from the start-bit edge.
      lat = 0;
      fork
         send_frame(8'h41, 1'b1);
         begin
            while (!stdin_valid && lat < 60) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("latency_A_in_40_to_42", 32'(lat >= 40 && lat <= 42), 32'h1);
      check("A_stdin", 32'(stdin), 32'h41);
      check("A_framing", 32'(framing_error), 32'h0);
      pop_check("A_pop", 8'h41);
      check("A_valid_after_pop", 32'(stdin_valid), 32'h0);

      foreach (vecs[i]) begin
         send_frame(vecs[i].data, 1'b1);
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(stdin_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_framing", i), 32'(framing_error), 32'h0);
         pop_check($sformatf("vec%0d_stdin", i), vecs[i].exp_stdin);
         check($sformatf("vec%0d_empty", i), 32'(stdin_valid), 32'h0);
      end

      // Back-to-back frames, then three consecutive pops.
      send_frame(8'h2B, 1'b1);
      send_frame(8'h5B, 1'b1);
      send_frame(8'h00, 1'b1);
      repeat (2) @(negedge clk);
      pop_check("b2b_0", 8'h2B);
      pop_check("b2b_1", 8'h5B);
      pop_check("b2b_2", 8'h00);
      check("b2b_empty", 32'(stdin_valid), 32'h0);

      // Overflow: five bytes into a depth-4 FIFO.
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      repeat (2) @(negedge clk);
      check("ovf_set", 32'(overflow), 32'h1);
      check("ovf_valid", 32'(stdin_valid), 32'h1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'h0);
      for (int i = 1; i <= 4; i++) pop_check($sformatf("ovf_pop%0d", i), 8'(i));
      check("ovf_empty", 32'(stdin_valid), 32'h0);

      // Two-cycle glitch must be rejected silently.
      uart_rx_pin = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx_pin = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch_valid", 32'(stdin_valid), 32'h0);
      check("glitch_framing", 32'(framing_error), 32'h0);
      send_frame(8'hFF, 1'b1);
      repeat (2) @(negedge clk);
      pop_check("glitch_then_FF", 8'hFF);

      // Bad stop bit with the line held low: one error only.
      send_frame(8'h55, 1'b0);
      repeat (40) @(negedge clk);
      check("fe_set", 32'(framing_error), 32'h1);
      check("fe_no_byte", 32'(stdin_valid), 32'h0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      repeat (4) @(negedge clk);
      check("fe_no_repeat_in_break", 32'(framing_error), 32'h0);
      uart_rx_pin = 1'b1;
      repeat (10) @(negedge clk);
      check("fe_no_repeat_after_high", 32'(framing_error), 32'h0);
      send_frame(8'hAA, 1'b1);
      repeat (2) @(negedge clk);
      check("fe_recover_framing", 32'(framing_error), 32'h0);
      pop_check("fe_recover_AA", 8'hAA);

      // Clear coinciding with the bad stop sample wins.
      send_frame(8'h33, 1'b0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("fe_clear_priority", 32'(framing_error), 32'h0);
      uart_rx_pin = 1'b1;
      repeat (10) @(negedge clk);

      // Push into a full FIFO while popping in the same cycle.
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
      send_frame(8'h14, 1'b1);
      stdin_rd = 1'b1;
      @(negedge clk);
      stdin_rd = 1'b0;
      @(negedge clk);
      check("full_pop_overflow", 32'(overflow), 32'h0);
      for (int i = 1; i <= 4; i++) pop_check($sformatf("full_pop%0d", i), 8'h10 + 8'(i));
      check("full_pop_empty", 32'(stdin_valid), 32'h0);

      // Reset in the middle of a frame with data and an error pending.
      send_frame(8'h77, 1'b1);
      send_frame(8'h0F, 1'b0);
      repeat (2) @(negedge clk);
      check("pre_rst_valid", 32'(stdin_valid), 32'h1);
      check("pre_rst_framing", 32'(framing_error), 32'h1);
      uart_rx_pin = 1'b1;
      repeat (6) @(negedge clk);
      uart_rx_pin = 1'b0;
      repeat (14) @(negedge clk);
      rst         = 1'b1;
      uart_rx_pin = 1'b1;
      @(negedge clk);
      check("rst_stdin", 32'(stdin), 32'h0);
      check("rst_valid", 32'(stdin_valid), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_framing", 32'(framing_error), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_valid", 32'(stdin_valid), 32'h0);
      send_frame(8'hC3, 1'b1);
      repeat (2) @(negedge clk);
      check("post_rst_framing", 32'(framing_error), 32'h0);
      pop_check("post_rst_C3", 8'hC3);
      check("post_rst_empty", 32'(stdin_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/bf_stdin_uart_rx.md
Name: bf_stdin_uart_rx

Overview:
- UART receiver plus byte FIFO that supplies the stdin side of the brainfuck CPU core, i.e. the bytes consumed by its ',' instruction.
- Mirrors the existing stdout/uart_tx path: serial bytes arrive on uart_rx_pin and are deserialised in the fast clk domain.
- Received bytes are buffered and presented to the CPU as a show-ahead byte with a valid flag and a read strobe.

Parameters:
- UART_RX_BAUD, 4, clk cycles per bit; legal range >= 2. Matches UART_TX_BAUD for loopback.
- FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 bytes.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx_pin  input  1  serial in; idle high, 8N1, LSB first; asynchronous to clk.
- stdin  output  8  FIFO head byte; valid only while stdin_valid=1.
- stdin_valid  output  1  FIFO not empty.
- stdin_rd  input  1  one-cycle pop strobe from the CPU; ignored when stdin_valid=0.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- framing_error  output  1  sticky; a stop bit was sampled low.
- err_clear  input  1  clears overflow and framing_error on the next clk edge.

Behaviour:
- Reset (async assert; deassert is registered):
  - stdin=0, stdin_valid=0, overflow=0, framing_error=0.
  - FIFO empty; FSM in IDLE; synchroniser flops preset to 1.
- Reset mid-frame or mid-FIFO aborts the frame and discards all buffered bytes.
- Synchroniser: 2 flops on uart_rx_pin give rx_s. All FSM decisions use rx_s, adding 2 cycles of latency.
- Bit counter: reloads on every state entry. Half-bit = UART_RX_BAUD/2 (integer division); full bit = UART_RX_BAUD.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START; load half-bit count.
  - START: at count expiry, sample rx_s.
    - 1 -> IDLE (glitch rejected, no error).
    - 0 -> DATA; bit index 0; load full-bit count.
  - DATA: at each expiry, shift rx_s into bit[index] (LSB first).
    - After bit 7 -> STOP; load full-bit count.
  - STOP: at expiry, sample rx_s.
    - 1 -> push byte; -> IDLE.
    - 0 -> set framing_error; discard byte; -> BREAK.
  - BREAK: stay until rx_s==1, then -> IDLE. A held-low line produces only one framing error.
- FIFO push:
  - Occurs in the same cycle as the STOP sample with rx_s==1.
  - Accepted if count < depth, or if count == depth and stdin_rd=1 in that cycle (simultaneous pop frees the slot).
  - Otherwise the byte is dropped and overflow is set.
- FIFO pop: when stdin_rd=1 and stdin_valid=1, advance the read pointer.
- stdin/stdin_valid update on the clk edge after a push or pop; show-ahead from the registered head.
- Push on an empty FIFO: stdin_valid rises the cycle after the push cycle.
- Pointers are FIFO_DEPTH_LOG2 bits wide and wrap modulo depth. Occupancy counter is FIFO_DEPTH_LOG2+1 bits, range 0..depth.
- Simultaneous push and pop at count 0 < n < depth: count unchanged; both pointers advance.
- err_clear has priority over set in the same cycle: flags read 0 next cycle. An error event coinciding with err_clear is lost.
- End-to-end latency from start-bit falling edge on the pin to stdin_valid=1: 2 + UART_RX_BAUD/2 + 9*UART_RX_BAUD + 1 cycles, ±1 for edge alignment.

Test Plan:
- BAUD=4, depth=4: send 0x41 ('A') 8N1 -> stdin=0x41 and stdin_valid=1 within 41 ±1 cycles of the start edge; framing_error=0.
- Send 0x2B, 0x5B, 0x00 back-to-back, then pulse stdin_rd three times one cycle apart -> stdin shows 0x2B, 0x5B, 0x00 in order; stdin_valid=0 after the third pop.
- Send 5 bytes 0x01..0x05 with no reads (depth 4) -> FIFO holds 0x01..0x04, overflow=1. Then err_clear -> overflow=0.
- Drive a 2-clk low glitch on an idle line -> no byte, no error, FSM back in IDLE. Then send 0xFF -> received correctly.
- Send 0x55 with stop bit low, line held low 40 cycles, then high -> framing_error=1, stdin_valid=0, exactly one error. Next byte 0xAA received.
- With FIFO full, send a byte whose stop sample coincides with stdin_rd=1 -> byte accepted, count stays 4, overflow=0. Separately, assert rst mid-frame -> all outputs 0 and a subsequent byte is received cleanly.
